// File: rtl/reg_splitter_pkg.sv
// reg_splitter_pkg: shared state encoding, default widths and byte-lane helper
// for the reg_splitter word-to-byte serializer.
package reg_splitter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // LSB position of byte slot k when bytes go out MSB first.
  function automatic int byte_lsb(input int nb, input int k, input int out_w);
    return (nb - 1 - k) * out_w;
  endfunction

endpackage

// File: rtl/reg_splitter_edge.sv
// edge_detect_rise: registers the request line and flags a low-to-high change.
// The previous-sample register resets to 0, so a line already high when reset
// releases reads as a rising edge on the first clock.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember the previous sample of the request line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/reg_splitter.sv
// reg_splitter: captures a DATA_W word on a rising edge of write and emits it
// as DATA_W/OUT_W bytes, MSB first, each qualified by a one-cycle enable.
// Each byte slot lasts HOLD_CYCLES cycles. DATA_W must be a multiple of OUT_W.
// Optional: define REG_SPLITTER_BUSY_EN to add the registered busy output.
module reg_splitter
  import reg_splitter_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [DATA_W-1:0] adcReg,
  output logic              enable,
  output logic [OUT_W-1:0]  register
`ifdef REG_SPLITTER_BUSY_EN
  ,
  output logic              busy
`endif
);

  localparam int NB    = DATA_W / OUT_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES > 1) ? (HOLD_CYCLES - 2) : 0);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   idx_nxt_s;
  logic [CNT_W-1:0]   hold_r;
  logic [CNT_W-1:0]   hold_nxt_s;
  logic [DATA_W-1:0]  shadow_r;
  logic [OUT_W-1:0]   byte_s;
  logic               start_s;

  edge_detect_rise u_edge (
    .clk   (clk),
    .rst_n (rst),
    .din   (write),
    .rise  (start_s)
  );

  // FSM state, byte index and gap counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      hold_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  // Next-state logic: one SEND cycle per byte, followed by HOLD_CYCLES-1 GAP
  // cycles when slots are wider than one clock. Starts outside IDLE are dropped.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    hold_nxt_s  = hold_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = SEND;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        hold_nxt_s = '0;
        if (HOLD_CYCLES > 1) begin
          state_nxt_s = GAP;
        end else if (idx_r == IDX_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          idx_nxt_s   = idx_r + IDX_W'(1);
          state_nxt_s = SEND;
        end
      end
      GAP: begin
        if (hold_r == HOLD_LAST) begin
          hold_nxt_s = '0;
          if (idx_r == IDX_LAST) begin
            state_nxt_s = IDLE;
          end else begin
            idx_nxt_s   = idx_r + IDX_W'(1);
            state_nxt_s = SEND;
          end
        end else begin
          hold_nxt_s = hold_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = '0;
        hold_nxt_s  = '0;
      end
    endcase
  end

  // Shadow copy of the word, taken only on an accepted start so later input
  // changes cannot disturb a burst in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r <= '0;
    end else if ((state_r == IDLE) && start_s) begin
      shadow_r <= adcReg;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Byte-lane mux: slot idx selects byte NB-1-idx of the shadow word.
  always_comb begin
    byte_s = '0;
    for (int k = 0; k < NB; k++) begin
      if (idx_r == IDX_W'(k)) begin
        byte_s = shadow_r[byte_lsb(NB, k, OUT_W) +: OUT_W];
      end else begin
        byte_s = byte_s;
      end
    end
  end

  // Registered outputs: strobe and byte update in SEND, byte held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable   <= 1'b0;
      register <= '0;
    end else if (state_r == SEND) begin
      enable   <= 1'b1;
      register <= byte_s;
    end else begin
      enable   <= 1'b0;
      register <= register;
    end
  end

`ifdef REG_SPLITTER_BUSY_EN
  // Busy covers every slot of the burst, one edge behind the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_r != IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_reg_splitter.sv
// tb_reg_splitter: directed bench for reg_splitter. Instance a uses
// HOLD_CYCLES=1, instance b uses HOLD_CYCLES=3; both share the inputs.
// Build with REG_SPLITTER_BUSY_EN defined to also check busy.
module tb_reg_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [31:0] adc;
  logic        en_a, en_b;
  logic [7:0]  reg_a, reg_b;
`ifdef REG_SPLITTER_BUSY_EN
  logic        busy_a, busy_b;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] val_a[$];
  logic [7:0] val_b[$];
  int         cyc_a[$];
  int         cyc_b[$];
  int         busy_cnt_a, busy_cnt_b, gap_err_b;

  reg_splitter #(.DATA_W(32), .OUT_W(8), .HOLD_CYCLES(1)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .adcReg   (adc),
    .enable   (en_a),
    .register (reg_a)
`ifdef REG_SPLITTER_BUSY_EN
    ,
    .busy     (busy_a)
`endif
  );

  reg_splitter #(.DATA_W(32), .OUT_W(8), .HOLD_CYCLES(3)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .adcReg   (adc),
    .enable   (en_b),
    .register (reg_b)
`ifdef REG_SPLITTER_BUSY_EN
    ,
    .busy     (busy_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] word, input int k);
    logic [31:0] sh;
    sh = word >> (8 * (3 - k));
    return sh[7:0];
  endfunction

  // Drive write from wmask (bit c = level during cycle c), switch the word to
  // adc1 after cycle chg_cyc, and log every strobe seen on both instances.
  task automatic run(input logic [31:0] adc0, input logic [63:0] wmask,
                     input logic [31:0] adc1, input int chg_cyc, input int ncyc);
    val_a.delete(); val_b.delete(); cyc_a.delete(); cyc_b.delete();
    busy_cnt_a = 0; busy_cnt_b = 0; gap_err_b = 0;
    adc   = adc0;
    write = wmask[0];
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (en_a) begin
        val_a.push_back(reg_a);
        cyc_a.push_back(c);
      end
      if (en_b) begin
        val_b.push_back(reg_b);
        cyc_b.push_back(c);
      end else if (val_b.size() > 0 && reg_b !== val_b[$]) begin
        gap_err_b++;
      end
`ifdef REG_SPLITTER_BUSY_EN
      if (busy_a) busy_cnt_a++;
      if (busy_b) busy_cnt_b++;
`endif
      if (c == chg_cyc) adc = adc1;
      write = (c < 64) ? wmask[c] : 1'b0;
    end
    write = 1'b0;
  endtask

  // Compare logged strobes of instance a against nbursts copies of word.
  task automatic check_a(input string tag, input logic [31:0] word, input int nbursts,
                         input int period);
    check({tag, "_count"}, val_a.size(), 4 * nbursts);
    for (int i = 0; i < val_a.size() && i < 4 * nbursts; i++) begin
      check($sformatf("%s_byte%0d", tag, i), val_a[i], exp_byte(word, i % 4));
      check($sformatf("%s_cyc%0d", tag, i), cyc_a[i], 2 + period * (i / 4) + (i % 4));
    end
  endtask

  initial begin
    logic [63:0] tmask;
    rst   = 1'b0;
    write = 1'b0;
    adc   = 32'h0;
    step();
    step();
    check("rst_en", en_a, 1'b0);
    check("rst_reg", reg_a, 8'h00);
    check("rst_en_b", en_b, 1'b0);
`ifdef REG_SPLITTER_BUSY_EN
    check("rst_busy", busy_a, 1'b0);
`endif
    rst = 1'b1;
    step();

    // Nominal pulse burst.
    run(32'h57494E20, 64'h1, 32'h0, -1, 10);
    check_a("nominal", 32'h57494E20, 1, 0);
    check("nominal_hold_reg", reg_a, 8'h20);
    check("nominal_idle_en", en_a, 1'b0);

    // Write held high for 20 cycles gives one burst.
    run(32'h57494E20, 64'hFFFFF, 32'h0, -1, 30);
    check_a("level", 32'h57494E20, 1, 0);

    // Second rising edge during the burst with a new word is ignored.
    run(32'h57494E20, 64'hD, 32'h11223344, 1, 16);
    check_a("ignore", 32'h57494E20, 1, 0);

    // Toggle write every 5 cycles: four bursts, 10 cycles apart.
    tmask = '0;
    for (int c = 0; c < 40; c++) tmask[c] = ((c / 5) % 2) == 0;
    run(32'h57494E20, tmask, 32'h0, -1, 45);
    check_a("toggle", 32'h57494E20, 4, 10);
`ifdef REG_SPLITTER_BUSY_EN
    check("toggle_busy", busy_cnt_a, 16);
`endif

    // Spacing with HOLD_CYCLES=3 on instance b, from a clean reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    run(32'hA1B2C3D4, 64'h1, 32'h0, -1, 20);
    check("space_count", val_b.size(), 4);
    for (int i = 0; i < val_b.size() && i < 4; i++) begin
      check($sformatf("space_byte%0d", i), val_b[i], exp_byte(32'hA1B2C3D4, i));
      check($sformatf("space_cyc%0d", i), cyc_b[i], 2 + 3 * i);
    end
    check("space_gap_stable", gap_err_b, 0);
    check("space_hold_reg", reg_b, 8'hD4);
`ifdef REG_SPLITTER_BUSY_EN
    check("space_busy", busy_cnt_b, 12);
`endif

    // Reset mid-burst clears outputs without a clock edge and aborts.
    adc   = 32'h57494E20;
    write = 1'b1;
    step();
    write = 1'b0;
    step();
    check("mid_pre_en", en_a, 1'b1);
    check("mid_pre_reg", reg_a, 8'h57);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_en", en_a, 1'b0);
    check("mid_rst_reg", reg_a, 8'h00);
`ifdef REG_SPLITTER_BUSY_EN
    check("mid_rst_busy", busy_a, 1'b0);
`endif
    step();
    step();
    rst = 1'b1;
    run(32'h57494E20, 64'h0, 32'h0, -1, 8);
    check("mid_abort_count", val_a.size(), 0);
    check("mid_abort_reg", reg_a, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
